// File: rtl/psum_wb_if.sv
// Partial-sum write-back bundle: row push side, block-RAM write port and status.
// PSUM_WB_PERF_EN adds the stall_cnt / wr_cnt performance counters.
interface psum_wb_if #(
   parameter int ARRAY_ROWS = 3,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32
);
   logic [ARRAY_ROWS-1:0]             psum_valid;
   logic [ARRAY_ROWS-1:0][ADDR_W-1:0] psum_addr;
   logic [ARRAY_ROWS-1:0][DATA_W-1:0] psum_data;
   logic [ARRAY_ROWS-1:0]             psum_ready;
   logic                              wr_en;
   logic [ADDR_W-1:0]                 wr_addr;
   logic [DATA_W-1:0]                 wr_data;
   logic                              wr_ready;
   logic                              clr_overflow;
   logic [ARRAY_ROWS-1:0]             overflow;
   logic                              drained;
`ifdef PSUM_WB_PERF_EN
   logic [31:0]                       stall_cnt;
   logic [31:0]                       wr_cnt;

   modport master (
      output psum_valid, psum_addr, psum_data, wr_ready, clr_overflow,
      input  psum_ready, wr_en, wr_addr, wr_data, overflow, drained, stall_cnt, wr_cnt
   );
   modport slave (
      input  psum_valid, psum_addr, psum_data, wr_ready, clr_overflow,
      output psum_ready, wr_en, wr_addr, wr_data, overflow, drained, stall_cnt, wr_cnt
   );
`else
   modport master (
      output psum_valid, psum_addr, psum_data, wr_ready, clr_overflow,
      input  psum_ready, wr_en, wr_addr, wr_data, overflow, drained
   );
   modport slave (
      input  psum_valid, psum_addr, psum_data, wr_ready, clr_overflow,
      output psum_ready, wr_en, wr_addr, wr_data, overflow, drained
   );
`endif
endinterface

// File: rtl/psum_wb_arbiter.sv
// Per-row psum FIFOs, round-robin arbitration onto one registered block-RAM write port.
// Optional PSUM_WB_PERF_EN: stall_cnt (saturating) and wr_cnt (wrapping) counters.
module psum_wb_arbiter #(
   parameter int ARRAY_ROWS = 3,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   psum_wb_if.slave      bus_io
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int RW = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1;
   localparam int EW = ADDR_W + DATA_W;

   logic [EW-1:0]                   mem_q [ARRAY_ROWS][FIFO_DEPTH];
   logic [ARRAY_ROWS-1:0][PW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ARRAY_ROWS-1:0]           full, empty, push, drop, pop;
   logic [ARRAY_ROWS-1:0]           overflow_q, overflow_d;
   logic [RW-1:0]                   rr_ptr_q, rr_ptr_d, grant;
   logic                            found, load, take;
   logic                            wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]               wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]               wr_data_q, wr_data_d;
   logic [EW-1:0]                   head;
   int                              idx;

   // Pointers carry one wrap bit: equal low bits with differing wrap bits means full.
   always_comb begin
      for (int i = 0; i < ARRAY_ROWS; i++) begin
         full[i]  = (wptr_q[i][PW] != rptr_q[i][PW]) &&
                    (wptr_q[i][PW-1:0] == rptr_q[i][PW-1:0]);
         empty[i] = (wptr_q[i] == rptr_q[i]);
      end
   end

   assign push = bus_io.psum_valid & ~full;
   assign drop = bus_io.psum_valid & full;

   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int j = 0; j < ARRAY_ROWS; j++) begin
         idx = int'(rr_ptr_q) + j;
         if (idx >= ARRAY_ROWS) idx = idx - ARRAY_ROWS;
         if (!found && !empty[idx]) begin
            found = 1'b1;
            grant = RW'(idx);
         end
      end
   end

   // Output register refills when empty or when its word is accepted this cycle.
   assign load = !wr_en_q || bus_io.wr_ready;
   assign take = load && found;
   assign head = mem_q[grant][rptr_q[grant][PW-1:0]];

   always_comb begin
      wr_en_d    = wr_en_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rr_ptr_d   = rr_ptr_q;
      pop        = '0;
      overflow_d = (overflow_q & ~{ARRAY_ROWS{bus_io.clr_overflow}}) | drop;
      if (load) wr_en_d = found;
      if (take) begin
         {wr_addr_d, wr_data_d} = head;
         rr_ptr_d = (grant == RW'(ARRAY_ROWS - 1)) ? '0 : grant + 1'b1;
      end
      for (int i = 0; i < ARRAY_ROWS; i++) begin
         pop[i]    = take && (grant == RW'(i));
         wptr_d[i] = wptr_q[i] + (PW+1)'(push[i]);
         rptr_d[i] = rptr_q[i] + (PW+1)'(pop[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         rr_ptr_q   <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         overflow_q <= '0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         rr_ptr_q   <= rr_ptr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < ARRAY_ROWS; i++) begin
         if (push[i]) mem_q[i][wptr_q[i][PW-1:0]] <= {bus_io.psum_addr[i], bus_io.psum_data[i]};
      end
   end

   assign bus_io.psum_ready = ~full;
   assign bus_io.wr_en      = wr_en_q;
   assign bus_io.wr_addr    = wr_addr_q;
   assign bus_io.wr_data    = wr_data_q;
   assign bus_io.overflow   = overflow_q;
   assign bus_io.drained    = (&empty) && !wr_en_q;

`ifdef PSUM_WB_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, wr_cnt_q, wr_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      if (wr_en_q && !bus_io.wr_ready && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (wr_en_q && bus_io.wr_ready)
         wr_cnt_d = wr_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         wr_cnt_q    <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
      end
   end

   assign bus_io.stall_cnt = stall_cnt_q;
   assign bus_io.wr_cnt    = wr_cnt_q;
`endif
endmodule

// File: tb/tb_psum_wb_arbiter.sv
// Scoreboard bench for psum_wb_arbiter; perf counters checked when PSUM_WB_PERF_EN is defined.
module tb_psum_wb_arbiter;
   localparam int ROWS = 3;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;
   int   n_acc = 0;
   exp_t sb[$];
   exp_t e;

   psum_wb_if #(.ARRAY_ROWS(ROWS), .DATA_W(32), .ADDR_W(32)) bus ();

   psum_wb_arbiter #(.ARRAY_ROWS(ROWS), .DATA_W(32), .ADDR_W(32), .FIFO_DEPTH(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   // Accepted writes are popped from the scoreboard mid-cycle.
   always @(negedge clk) begin
      if (!rst && bus.wr_en === 1'b1 && bus.wr_ready === 1'b1) begin
         n_acc++;
         n_chk++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL wr_unexpected got addr=%h data=%h, expected no write", bus.wr_addr, bus.wr_data);
         end else begin
            e = sb.pop_front();
            if (bus.wr_addr !== e.a || bus.wr_data !== e.d) begin
               n_bad++;
               $display("FAIL wr_word got addr=%h data=%h, expected addr=%h data=%h",
                        bus.wr_addr, bus.wr_data, e.a, e.d);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input int r, input logic [31:0] a, input logic [31:0] d);
      bus.psum_valid[r] = 1'b1;
      bus.psum_addr[r]  = a;
      bus.psum_data[r]  = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.psum_valid   = '0;
      bus.wr_ready     = 1'b1;
      bus.clr_overflow = 1'b0;
      sb.delete();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (sb.size() == 0 && bus.drained === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_chk++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s_drain got pending=%0d drained=%b, expected pending=0 drained=1", name, sb.size(), bus.drained);
      end
   endtask

   task automatic test_reset();
      bus.psum_addr = '0;
      bus.psum_data = '0;
      do_reset();
      n_chk++;
      if (bus.wr_en !== 1'b0 || bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_wr got en=%b addr=%h data=%h, expected 0/0/0", bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      n_chk++;
      if (bus.psum_ready !== 3'b111 || bus.overflow !== 3'b000 || bus.drained !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_status got ready=%b ovf=%b drained=%b, expected 111/000/1",
                  bus.psum_ready, bus.overflow, bus.drained);
      end
   endtask

   task automatic test_single();
      do_reset();
      drive_push(1, 32'h10, 32'hAB);
      sb.push_back('{a: 32'h10, d: 32'hAB});
      tick();
      bus.psum_valid = '0;
      n_chk++;
      if (bus.wr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL single_early got wr_en=%b, expected 0", bus.wr_en);
      end
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 32'h10 || bus.wr_data !== 32'hAB) begin
         n_bad++;
         $display("FAIL single_latency got en=%b addr=%h data=%h, expected 1/10/ab", bus.wr_en, bus.wr_addr, bus.wr_data);
      end
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b0 || bus.drained !== 1'b1) begin
         n_bad++;
         $display("FAIL single_done got en=%b drained=%b, expected 0/1", bus.wr_en, bus.drained);
      end
      wait_drain("single");
   endtask

   task automatic test_all_rows();
      do_reset();
      for (int r = 0; r < ROWS; r++) begin
         drive_push(r, r, 32'hC0 + r);
         sb.push_back('{a: r, d: 32'hC0 + r});
      end
      tick();
      bus.psum_valid = '0;
      for (int r = 0; r < ROWS; r++) begin
         tick();
         n_chk++;
         if (bus.wr_en !== 1'b1 || bus.wr_addr !== 32'(r)) begin
            n_bad++;
            $display("FAIL all_rows_order got en=%b addr=%h, expected 1/%h", bus.wr_en, bus.wr_addr, r);
         end
      end
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b0) begin
         n_bad++;
         $display("FAIL all_rows_end got wr_en=%b, expected 0", bus.wr_en);
      end
      // Pointer should be back at row 0: row 0 must win over row 2.
      drive_push(2, 32'h2F, 32'h22);
      drive_push(0, 32'h0F, 32'h11);
      sb.push_back('{a: 32'h0F, d: 32'h11});
      sb.push_back('{a: 32'h2F, d: 32'h22});
      tick();
      bus.psum_valid = '0;
      wait_drain("all_rows");
   endtask

   task automatic test_overflow();
      do_reset();
      bus.wr_ready = 1'b0;
      for (int s = 0; s < 6; s++) begin
         drive_push(0, 32'h100 + s, 32'hD0 + s);
         if (s < 5) sb.push_back('{a: 32'h100 + s, d: 32'hD0 + s});
         tick();
         n_chk++;
         if (bus.psum_ready[0] !== (s < 4)) begin
            n_bad++;
            $display("FAIL ovf_ready step=%0d got %b, expected %b", s, bus.psum_ready[0], (s < 4));
         end
         n_chk++;
         if (bus.overflow !== ((s == 5) ? 3'b001 : 3'b000)) begin
            n_bad++;
            $display("FAIL ovf_flag step=%0d got %b, expected %b", s, bus.overflow, (s == 5) ? 3'b001 : 3'b000);
         end
      end
      bus.psum_valid = '0;
      tick();
      n_chk++;
      if (bus.overflow !== 3'b001) begin
         n_bad++;
         $display("FAIL ovf_sticky got %b, expected 001", bus.overflow);
      end
      drive_push(0, 32'hDEAD, 32'hDEAD);
      bus.clr_overflow = 1'b1;
      tick();
      n_chk++;
      if (bus.overflow !== 3'b001) begin
         n_bad++;
         $display("FAIL ovf_set_wins got %b, expected 001", bus.overflow);
      end
      bus.psum_valid = '0;
      tick();
      bus.clr_overflow = 1'b0;
      n_chk++;
      if (bus.overflow !== 3'b000) begin
         n_bad++;
         $display("FAIL ovf_clear got %b, expected 000", bus.overflow);
      end
      bus.wr_ready = 1'b1;
      wait_drain("overflow");
   endtask

   task automatic test_stall();
      int acc0;
      do_reset();
      bus.wr_ready = 1'b0;
      drive_push(2, 32'h2A0, 32'h5A5A);
      sb.push_back('{a: 32'h2A0, d: 32'h5A5A});
      tick();
      bus.psum_valid = '0;
      tick();
      acc0 = n_acc;
      for (int k = 0; k < 3; k++) begin
         n_chk++;
         if (bus.wr_en !== 1'b1 || bus.wr_addr !== 32'h2A0 || bus.wr_data !== 32'h5A5A) begin
            n_bad++;
            $display("FAIL stall_hold cyc=%0d got en=%b addr=%h data=%h, expected 1/2a0/5a5a",
                     k, bus.wr_en, bus.wr_addr, bus.wr_data);
         end
         tick();
      end
      bus.wr_ready = 1'b1;
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b0 || n_acc - acc0 != 1) begin
         n_bad++;
         $display("FAIL stall_accept got en=%b writes=%0d, expected 0/1", bus.wr_en, n_acc - acc0);
      end
`ifdef PSUM_WB_PERF_EN
      n_chk++;
      if (bus.stall_cnt !== 32'd3 || bus.wr_cnt !== 32'd1) begin
         n_bad++;
         $display("FAIL stall_perf got stall=%0d wr=%0d, expected 3/1", bus.stall_cnt, bus.wr_cnt);
      end
`endif
      wait_drain("stall");
   endtask

   task automatic test_fairness();
      do_reset();
      for (int s = 0; s < 4; s++) begin
         drive_push(0, 32'h000 + s, 32'hA0 + s);
         drive_push(2, 32'h200 + s, 32'hB0 + s);
         sb.push_back('{a: 32'h000 + s, d: 32'hA0 + s});
         sb.push_back('{a: 32'h200 + s, d: 32'hB0 + s});
         tick();
      end
      bus.psum_valid = '0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_chk++;
         if (bus.wr_en !== 1'b1) begin
            n_bad++;
            $display("FAIL fair_no_bubble cyc=%0d got wr_en=%b, expected 1", k, bus.wr_en);
         end
      end
      wait_drain("fairness");
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.wr_ready = 1'b0;
      for (int r = 0; r < ROWS; r++) drive_push(r, 32'h300 + r, 32'hE0 + r);
      tick();
      bus.psum_valid = '0;
      tick();
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b1 || bus.drained !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_pre got en=%b drained=%b, expected 1/0", bus.wr_en, bus.drained);
      end
      rst = 1'b1;
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b0 || bus.drained !== 1'b1 || bus.overflow !== 3'b000 || bus.psum_ready !== 3'b111) begin
         n_bad++;
         $display("FAIL rstmid_state got en=%b drained=%b ovf=%b ready=%b, expected 0/1/000/111",
                  bus.wr_en, bus.drained, bus.overflow, bus.psum_ready);
      end
`ifdef PSUM_WB_PERF_EN
      n_chk++;
      if (bus.stall_cnt !== 32'd0 || bus.wr_cnt !== 32'd0) begin
         n_bad++;
         $display("FAIL rstmid_perf got stall=%0d wr=%0d, expected 0/0", bus.stall_cnt, bus.wr_cnt);
      end
`endif
      rst = 1'b0;
      bus.wr_ready = 1'b1;
      tick();
      tick();
      tick();
      n_chk++;
      if (bus.wr_en !== 1'b0 || bus.drained !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_discard got en=%b drained=%b, expected 0/1", bus.wr_en, bus.drained);
      end
   endtask

   initial begin
      bus.psum_valid   = '0;
      bus.wr_ready     = 1'b1;
      bus.clr_overflow = 1'b0;
      test_reset();
      test_single();
      test_all_rows();
      test_overflow();
      test_stall();
      test_fairness();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
